// File: rtl/pc_fetch_unit.sv
// IF-stage fetch engine: owns the PC, fetches one instruction per PC over a
// req/ack instruction-memory handshake and offers if_pc/if_inst to IF/ID.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic        flush,
    input  logic [31:0] new_pc,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_address_i,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_data_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        stallreq_from_if
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_BUSY    = 2'd1,
        S_HOLD    = 2'd2,
        S_DISCARD = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] r_inst_q;
    logic [31:0] r_mem_addr;
    logic        r_mem_req;
    logic        w_ack_busy;
    logic        w_stallreq;
    logic        w_accept;
    logic [31:0] w_next_pc;
    logic        w_unused_stall;

    // Only stall[1] (IF/ID hold) concerns the fetch stage.
    assign w_unused_stall = ^{stall[5:2], stall[0]};

    assign w_accept  = !w_stallreq && !stall[1];
    assign w_next_pc = branch_flag_i ? branch_target_address_i : r_pc + 32'd4;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; flush outranks acceptance, but an open bus request must still see its ack.
    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            if ((r_state == S_BUSY || r_state == S_DISCARD) && !mem_ack_i) begin
                w_state_nxt = S_DISCARD;
            end else begin
                w_state_nxt = S_IDLE;
            end
        end else begin
            case (r_state)
                S_IDLE:    w_state_nxt = S_BUSY;
                S_BUSY: begin
                    if (mem_ack_i) begin
                        w_state_nxt = w_accept ? S_IDLE : S_HOLD;
                    end else begin
                        w_state_nxt = S_BUSY;
                    end
                end
                S_HOLD:    w_state_nxt = w_accept ? S_IDLE : S_HOLD;
                S_DISCARD: w_state_nxt = mem_ack_i ? S_IDLE : S_DISCARD;
                default:   w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Output decode: an instruction is available when held, or when memory answers while BUSY.
    always_comb begin
        w_ack_busy = 1'b0;
        w_stallreq = 1'b1;
        case (r_state)
            S_IDLE:    w_stallreq = 1'b1;
            S_BUSY: begin
                w_ack_busy = mem_ack_i;
                w_stallreq = !mem_ack_i;
            end
            S_HOLD:    w_stallreq = 1'b0;
            S_DISCARD: w_stallreq = 1'b1;
            default:   w_stallreq = 1'b1;
        endcase
    end

    // PC, captured instruction and bus request registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc       <= RESET_PC;
            r_inst_q   <= 32'h0000_0000;
            r_mem_req  <= 1'b0;
            r_mem_addr <= 32'h0000_0000;
        end else if (flush) begin
            r_pc     <= new_pc;
            r_inst_q <= 32'h0000_0000;
            if ((r_state == S_BUSY || r_state == S_DISCARD) && mem_ack_i) begin
                r_mem_req <= 1'b0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_mem_req  <= 1'b1;
                    r_mem_addr <= r_pc;
                end
                S_BUSY: begin
                    if (mem_ack_i) begin
                        r_mem_req <= 1'b0;
                        r_inst_q  <= mem_data_i;
                        if (w_accept) begin
                            r_pc <= w_next_pc;
                        end
                    end
                end
                S_HOLD: begin
                    if (w_accept) begin
                        r_pc <= w_next_pc;
                    end
                end
                S_DISCARD: begin
                    if (mem_ack_i) begin
                        r_mem_req <= 1'b0;
                    end
                end
                default: begin
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req_o        = r_mem_req;
    assign mem_addr_o       = r_mem_addr;
    assign if_pc            = r_pc;
    assign if_inst          = w_ack_busy ? mem_data_i : r_inst_q;
    assign stallreq_from_if = w_stallreq;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed cycle table, a flush-in-DISCARD sequence,
// then randomized traffic against a transaction-level fetch model.
module tb_pc_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] D1 = 32'h2401_0001;
    localparam logic [31:0] D2 = 32'h3c01_1234;
    localparam logic [31:0] D3 = 32'h1111_1111;
    localparam logic [31:0] D4 = 32'h2222_2222;
    localparam logic [31:0] D5 = 32'h5555_5555;
    localparam logic [31:0] D6 = 32'h6666_6666;
    localparam int          N_RND = 3000;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        branch_flag_i;
    logic [31:0] branch_target_address_i;
    logic        mem_ack_i;
    logic [31:0] mem_data_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        stallreq_from_if;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pc_fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .stall                   (stall),
        .flush                   (flush),
        .new_pc                  (new_pc),
        .branch_flag_i           (branch_flag_i),
        .branch_target_address_i (branch_target_address_i),
        .mem_ack_i               (mem_ack_i),
        .mem_data_i              (mem_data_i),
        .mem_req_o               (mem_req_o),
        .mem_addr_o              (mem_addr_o),
        .if_pc                   (if_pc),
        .if_inst                 (if_inst),
        .stallreq_from_if        (stallreq_from_if)
    );

    typedef struct {
        logic        rst;
        logic        s1;
        logic        fl;
        logic [31:0] npc;
        logic        br;
        logic [31:0] tgt;
        logic        ack;
        logic [31:0] data;
        logic        chk;
        logic        e_req;
        logic [31:0] e_addr;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
        logic        e_sr;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic r, s1, fl, input logic [31:0] npc,
                                input logic br, input logic [31:0] tgt,
                                input logic ack, input logic [31:0] data,
                                input logic chk, e_req, input logic [31:0] e_addr,
                                input logic [31:0] e_pc, e_inst, input logic e_sr);
        vec_t v;
        v.rst = r;  v.s1 = s1;  v.fl = fl;  v.npc = npc;  v.br = br;  v.tgt = tgt;
        v.ack = ack; v.data = data; v.chk = chk; v.e_req = e_req; v.e_addr = e_addr;
        v.e_pc = e_pc; v.e_inst = e_inst; v.e_sr = e_sr;
        return v;
    endfunction

    // Memory contents as a pure function of the address.
    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h2545_F491;
    endfunction

    function automatic logic [31:0] pick_addr();
        if ($urandom_range(0, 7) == 0) return 32'hFFFF_FFFC;
        return $urandom & 32'hFFFF_FFFC;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, s1, fl, input logic [31:0] npc, input logic b,
                         input logic [31:0] t, input logic a, input logic [31:0] d);
        rst = r;
        stall = {4'b0000, s1, 1'b0};
        flush = fl;
        new_pc = npc;
        branch_flag_i = b;
        branch_target_address_i = t;
        mem_ack_i = a;
        mem_data_i = d;
    endtask

    logic        prev_req, prev_ack, discard_pending, in_txn;
    logic [31:0] prev_addr, model_pc;
    int          wait_left, accepts, n;

    initial begin
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);

        // rst s1 fl npc br tgt ack data | chk req addr pc inst sr
        vq.push_back(mk(1,0,0,0,0,0,0,0,   0,0,0,0,0,1));
        vq.push_back(mk(1,0,0,0,0,0,0,0,   1,0,0,0,0,1));
        vq.push_back(mk(0,0,0,0,0,0,0,0,   1,0,0,0,0,1));
        vq.push_back(mk(0,0,0,0,0,0,1,D1,  1,1,0,0,D1,0));
        vq.push_back(mk(0,0,0,0,0,0,0,0,   1,0,0,4,D1,1));
        for (int k = 0; k < 3; k++) vq.push_back(mk(0,0,0,0,0,0,0,0, 1,1,4,4,D1,1));
        vq.push_back(mk(0,1,0,0,0,0,1,D2,  1,1,4,4,D2,0));
        vq.push_back(mk(0,1,0,0,0,0,0,0,   1,0,4,4,D2,0));
        vq.push_back(mk(0,1,0,0,0,0,0,0,   1,0,4,4,D2,0));
        vq.push_back(mk(0,0,0,0,0,0,0,0,   1,0,4,4,D2,0));
        vq.push_back(mk(0,0,0,0,0,0,0,0,   1,0,4,8,D2,1));
        vq.push_back(mk(0,0,0,0,1,32'h100,1,D3, 1,1,8,8,D3,0));
        vq.push_back(mk(0,0,0,0,0,0,0,0,   1,0,8,32'h100,D3,1));
        vq.push_back(mk(0,0,0,0,1,32'hFFFF_FFFC,1,D4, 1,1,32'h100,32'h100,D4,0));
        vq.push_back(mk(0,0,0,0,0,0,0,0,   1,0,32'h100,32'hFFFF_FFFC,D4,1));
        vq.push_back(mk(0,0,0,0,0,0,1,D5,  1,1,32'hFFFF_FFFC,32'hFFFF_FFFC,D5,0));
        vq.push_back(mk(0,0,0,0,0,0,0,0,   1,0,32'hFFFF_FFFC,0,D5,1));
        vq.push_back(mk(0,0,1,32'h180,0,0,0,0, 1,1,0,0,D5,1));
        vq.push_back(mk(0,0,0,0,0,0,0,0,   1,1,0,32'h180,0,1));
        vq.push_back(mk(0,0,0,0,0,0,1,D6,  1,1,0,32'h180,0,1));
        vq.push_back(mk(0,0,0,0,0,0,0,0,   1,0,0,32'h180,0,1));
        vq.push_back(mk(1,0,0,0,0,0,0,0,   1,1,32'h180,32'h180,0,1));
        vq.push_back(mk(0,0,0,0,0,0,1,32'h7777_7777, 1,0,0,0,0,1));
        vq.push_back(mk(0,0,0,0,0,0,0,0,   1,1,0,0,0,1));

        foreach (vq[i]) begin
            @(negedge clk);
            drive(vq[i].rst, vq[i].s1, vq[i].fl, vq[i].npc, vq[i].br, vq[i].tgt,
                  vq[i].ack, vq[i].data);
            #1;
            if (vq[i].chk) begin
                check($sformatf("v%0d_req", i),  32'(mem_req_o),        32'(vq[i].e_req));
                check($sformatf("v%0d_addr", i), mem_addr_o,            vq[i].e_addr);
                check($sformatf("v%0d_pc", i),   if_pc,                 vq[i].e_pc);
                check($sformatf("v%0d_inst", i), if_inst,               vq[i].e_inst);
                check($sformatf("v%0d_sr", i),   32'(stallreq_from_if), 32'(vq[i].e_sr));
            end
        end

        // Repeated flush while DISCARDing: pc follows the latest target, bus request is held.
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b1, 32'h200, 1'b0, 32'h0, 1'b0, 32'h0);
        #1 check("hs_sr_busy", 32'(stallreq_from_if), 32'd1);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b1, 32'h300, 1'b0, 32'h0, 1'b0, 32'h0);
        #1;
        check("hs_pc_first", if_pc, 32'h200);
        check("hs_req_held", 32'(mem_req_o), 32'd1);
        check("hs_addr_held", mem_addr_o, 32'h0);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF);
        #1;
        check("hs_pc_second", if_pc, 32'h300);
        check("hs_sr_drop", 32'(stallreq_from_if), 32'd1);
        check("hs_inst_drop", if_inst, 32'h0);
        n = 0;
        do begin
            @(negedge clk);
            drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
            #1;
            n++;
        end while (!mem_req_o && n < 5);
        check("hs_req_seen", 32'(mem_req_o), 32'd1);
        check("hs_req_addr", mem_addr_o, 32'h300);

        // Randomized traffic against the fetch model.
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        model_pc = RESET_PC;
        prev_req = 1'b0;
        prev_ack = 1'b0;
        prev_addr = 32'h0;
        discard_pending = 1'b0;
        in_txn = 1'b0;
        wait_left = 0;
        accepts = 0;
        for (int c = 0; c < N_RND; c++) begin
            @(negedge clk);
            if (prev_req) begin
                if (prev_ack) begin
                    check("rnd_req_drop", 32'(mem_req_o), 32'd0);
                end else begin
                    check("rnd_req_hold", 32'(mem_req_o), 32'd1);
                    check("rnd_addr_hold", mem_addr_o, prev_addr);
                end
            end else if (mem_req_o) begin
                check("rnd_req_addr", mem_addr_o, model_pc);
            end

            rst = 1'b0;
            stall = 6'($urandom);
            stall[1] = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 24) == 0);
            new_pc = pick_addr();
            branch_flag_i = ($urandom_range(0, 3) == 0);
            branch_target_address_i = pick_addr();
            if (mem_req_o) begin
                if (!in_txn) begin
                    in_txn = 1'b1;
                    wait_left = $urandom_range(0, 3);
                end
                if (wait_left == 0) begin
                    mem_ack_i = 1'b1;
                    mem_data_i = mem_fn(mem_addr_o);
                    in_txn = 1'b0;
                end else begin
                    mem_ack_i = 1'b0;
                    mem_data_i = $urandom;
                    wait_left--;
                end
            end else begin
                in_txn = 1'b0;
                mem_ack_i = ($urandom_range(0, 7) == 0);
                mem_data_i = $urandom;
            end
            #1;

            if (mem_req_o && mem_ack_i) begin
                check("rnd_sr_ack", 32'(stallreq_from_if), 32'(discard_pending));
            end else if (mem_req_o) begin
                check("rnd_sr_wait", 32'(stallreq_from_if), 32'd1);
            end
            if (!flush && !stallreq_from_if) begin
                check("rnd_if_pc", if_pc, model_pc);
                check("rnd_if_inst", if_inst, mem_fn(model_pc));
            end
            if (flush) begin
                model_pc = new_pc;
            end else if (!stallreq_from_if && !stall[1]) begin
                accepts++;
                model_pc = branch_flag_i ? branch_target_address_i : model_pc + 32'd4;
            end
            if (mem_req_o && mem_ack_i) discard_pending = 1'b0;
            if (flush && mem_req_o && !mem_ack_i) discard_pending = 1'b1;
            prev_req = mem_req_o;
            prev_ack = mem_ack_i;
            prev_addr = mem_addr_o;
        end
        check("rnd_progress", 32'(accepts >= N_RND / 20), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
